// File: rtl/alu_op_encoder.sv
// RV32I instruction -> ALU operation encoder with a single-entry output register.
// Optional: define ALU_OP_ENCODER_ILLEGAL_EN to flag unsupported instructions on 'illegal'.
module alu_op_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  Operation,
    output logic        alu_src,
    output logic        illegal,
    output logic [15:0] op_count
);

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SRA = 4'b0111,
        ALU_BEQ = 4'b1000,
        ALU_BNE = 4'b1001,
        ALU_BGE = 4'b1010,
        ALU_BLT = 4'b1011,
        ALU_SLT = 4'b1100
    } alu_op_e;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       accept;
    alu_op_e    dec_op;
    logic       dec_src;
    logic       dec_ok;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign alt    = instr[30];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // A held entry leaving this cycle frees the register for a new one.
    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        dec_op  = ALU_ADD;
        dec_src = 1'b0;
        dec_ok  = 1'b1;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                dec_src = (opcode == OPC_OP_IMM);
                case (funct3)
                    3'b000: dec_op = (opcode == OPC_OP && alt) ? ALU_SUB : ALU_ADD;
                    3'b001: dec_op = ALU_SLL;
                    3'b010: dec_op = ALU_SLT;
                    3'b011: dec_ok = 1'b0;
                    3'b100: dec_op = ALU_XOR;
                    3'b101: dec_op = alt ? ALU_SRA : ALU_SRL;
                    3'b110: dec_op = ALU_OR;
                    3'b111: dec_op = ALU_AND;
                endcase
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  dec_op = ALU_BEQ;
                    3'b001:  dec_op = ALU_BNE;
                    3'b100:  dec_op = ALU_BLT;
                    3'b101:  dec_op = ALU_BGE;
                    default: dec_ok = 1'b0;
                endcase
            end
            // Address / upper-immediate / jump forms all use the adder on an immediate.
            OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
                dec_op  = ALU_ADD;
                dec_src = 1'b1;
            end
            default: dec_ok = 1'b0;
        endcase

`ifdef ALU_OP_ENCODER_ILLEGAL_EN
        if (!dec_ok) begin
            dec_op  = ALU_AND;
            dec_src = 1'b0;
        end
`else
        if (!dec_ok) begin
            dec_op  = ALU_ADD;
            dec_src = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            out_valid <= 1'b0;
            Operation <= 4'b0000;
            alu_src   <= 1'b0;
            op_count  <= 16'd0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                Operation <= dec_op;
                alu_src   <= dec_src;
                op_count  <= op_count + 16'd1;
            end else if (flush || out_ready) begin
                // Flush discards the entry even when downstream is stalled.
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_OP_ENCODER_ILLEGAL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal <= 1'b0;
        end else if (accept) begin
            illegal <= !dec_ok;
        end
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_encoder.sv
// Scoreboard bench for alu_op_encoder: directed instructions push expected results,
// a negedge monitor pops and compares whenever the held entry is consumed.
`timescale 1ns/1ps
module tb_alu_op_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [3:0]  Operation;
    logic        alu_src;
    logic        illegal;
    logic [15:0] op_count;

    alu_op_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Operation (Operation),
        .alu_src   (alu_src),
        .illegal   (illegal),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] op;
        logic       src;
        logic       ill;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass = 0;
    int          stall_cycles = 0;
    logic [15:0] exp_count = 16'd0;

    function automatic exp_t mk(input logic [3:0] op, input logic src, input logic ill);
        exp_t e;
        e.op  = op;
        e.src = src;
        e.ill = ill;
        return e;
    endfunction

    // Unsupported instructions load a different result depending on the build.
`ifdef ALU_OP_ENCODER_ILLEGAL_EN
    localparam logic [3:0] BAD_OP  = 4'b0000;
    localparam logic       BAD_ILL = 1'b1;
`else
    localparam logic [3:0] BAD_OP  = 4'b0010;
    localparam logic       BAD_ILL = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one instruction and waits (bounded) until it is accepted.
    task automatic send(input logic [31:0] i, input exp_t e);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        instr = i;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                exp_count++;
                done = 1'b1;
            end else begin
                stall_cycles++;
            end
            step();
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL send_timeout: instr 0x%08h not accepted in 50 cycles", i);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && (flush || out_ready)) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: Operation 0x%0h with empty scoreboard", Operation);
            end else begin
                mon_e = q.pop_front();
                if (!flush) begin
                    check("Operation", 32'(Operation), 32'(mon_e.op));
                    check("alu_src", 32'(alu_src), 32'(mon_e.src));
                    check("illegal", 32'(illegal), 32'(mon_e.ill));
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_Operation"}, 32'(Operation), 32'd0);
        check({tag, "_alu_src"}, 32'(alu_src), 32'd0);
        check({tag, "_illegal"}, 32'(illegal), 32'd0);
        check({tag, "_op_count"}, 32'(op_count), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        // Reset with an instruction offered: it must be ignored.
        rst_n = 1'b0;
        in_valid = 1'b1;
        instr = 32'h00100093;
        out_ready = 1'b1;
        repeat (2) step();
        @(negedge clk);
        check_zero("reset");
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        step();

        // First transaction: sub, 1-cycle latency.
        send(32'h40B50533, mk(4'b0110, 1'b0, 1'b0));
        @(negedge clk);
        check("sub_out_valid", 32'(out_valid), 32'd1);
        check("sub_op_count", 32'(op_count), 32'd1);
        step();

        // Decode table, back-to-back with out_ready=1.
        stall_cycles = 0;
        send(32'h00B50533, mk(4'b0010, 1'b0, 1'b0)); // add
        send(32'h00209033, mk(4'b0100, 1'b0, 1'b0)); // sll
        send(32'h0020A033, mk(4'b1100, 1'b0, 1'b0)); // slt
        send(32'h0020C033, mk(4'b0011, 1'b0, 1'b0)); // xor
        send(32'h0020D033, mk(4'b0101, 1'b0, 1'b0)); // srl
        send(32'h4020D033, mk(4'b0111, 1'b0, 1'b0)); // sra
        send(32'h0020E033, mk(4'b0001, 1'b0, 1'b0)); // or
        send(32'h0020F033, mk(4'b0000, 1'b0, 1'b0)); // and
        send(32'h4030D093, mk(4'b0111, 1'b1, 1'b0)); // srai
        send(32'h0030D093, mk(4'b0101, 1'b1, 1'b0)); // srli
        send(32'h40000093, mk(4'b0010, 1'b1, 1'b0)); // addi, imm bit30 set: no SUB
        send(32'h00208063, mk(4'b1000, 1'b0, 1'b0)); // beq
        send(32'h00209063, mk(4'b1001, 1'b0, 1'b0)); // bne
        send(32'h0020C063, mk(4'b1011, 1'b0, 1'b0)); // blt
        send(32'h0020D063, mk(4'b1010, 1'b0, 1'b0)); // bge
        send(32'h0000A083, mk(4'b0010, 1'b1, 1'b0)); // lw
        send(32'h0010A023, mk(4'b0010, 1'b1, 1'b0)); // sw
        send(32'h000010B7, mk(4'b0010, 1'b1, 1'b0)); // lui
        send(32'h00001097, mk(4'b0010, 1'b1, 1'b0)); // auipc
        send(32'h0000006F, mk(4'b0010, 1'b1, 1'b0)); // jal
        send(32'h00008067, mk(4'b0010, 1'b1, 1'b0)); // jalr
        send(32'h0020B033, mk(BAD_OP, 1'b0, BAD_ILL)); // sltu
        send(32'h0010B093, mk(BAD_OP, 1'b0, BAD_ILL)); // sltiu
        send(32'h0020E063, mk(BAD_OP, 1'b0, BAD_ILL)); // bltu
        send(32'h0000007F, mk(BAD_OP, 1'b0, BAD_ILL)); // unknown opcode
        check("back_to_back_stalls", 32'(stall_cycles), 32'd0);
        repeat (2) step();
        check("table_drained", 32'(q.size()), 32'd0);
        check("table_op_count", 32'(op_count), 32'(exp_count));

        // Backpressure: second instruction waits, first one holds.
        out_ready = 1'b0;
        send(32'h4030D093, mk(4'b0111, 1'b1, 1'b0));
        in_valid = 1'b1;
        instr = 32'h0030D093;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_Operation", 32'(Operation), 32'b0111);
            check("stall_op_count", 32'(op_count), 32'(exp_count));
        end
        step();
        out_ready = 1'b1;
        send(32'h0030D093, mk(4'b0101, 1'b1, 1'b0));
        repeat (2) step();

        // Flush with nothing offered empties the register.
        out_ready = 1'b0;
        send(32'h00B50533, mk(4'b0010, 1'b0, 1'b0));
        flush = 1'b1;
        @(negedge clk);
        step();
        flush = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_op_count", 32'(op_count), 32'(exp_count));
        step();

        // Flush with a same-cycle accept keeps the new instruction.
        send(32'h00209033, mk(4'b0100, 1'b0, 1'b0));
        out_ready = 1'b1;
        flush = 1'b1;
        send(32'h0020C033, mk(4'b0011, 1'b0, 1'b0));
        flush = 1'b0;
        @(negedge clk);
        check("flush_accept_out_valid", 32'(out_valid), 32'd1);
        check("flush_accept_Operation", 32'(Operation), 32'b0011);
        repeat (2) step();

        // op_count wrap.
        while (exp_count != 16'hFFFF) send(32'h00100093, mk(4'b0010, 1'b1, 1'b0));
        repeat (2) step();
        check("count_ffff", 32'(op_count), 32'h0000FFFF);
        send(32'h00100093, mk(4'b0010, 1'b1, 1'b0));
        repeat (2) step();
        check("count_wrap", 32'(op_count), 32'd0);

        // Asynchronous reset mid-stream with an entry held and another offered.
        out_ready = 1'b0;
        send(32'h40B50533, mk(4'b0110, 1'b0, 1'b0));
        in_valid = 1'b1;
        instr = 32'h0020F033;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        q.delete();
        exp_count = 16'd0;
        out_ready = 1'b1;
        repeat (2) step();
        @(negedge clk);
        check("reset_accept_ignored", 32'(op_count), 32'd0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        step();
        send(32'h0020F033, mk(4'b0000, 1'b0, 1'b0));
        @(negedge clk);
        check("post_reset_op_count", 32'(op_count), 32'd1);
        repeat (3) step();
        check("final_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_op_encoder.md
ALU_OP_ENCODER -- requirements
Module: alu_op_encoder

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  upstream instruction valid.
REQ-005 in_ready  output  1  encoder can accept an instruction this cycle.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 flush  input  1  discard the held entry (branch redirect).
REQ-008 out_valid  output  1  held Operation valid toward the ALU stage.
REQ-009 out_ready  input  1  downstream consumes the held entry.
REQ-010 Operation  output  4  ALU operation code.
REQ-011 alu_src  output  1  1 = SrcB from immediate, 0 = from register.
REQ-012 illegal  output  1  held instruction unsupported.
REQ-013 op_count  output  16  number of accepted instructions.

Function
REQ-014 SHALL hold a single-entry output register; in_ready = !out_valid | out_ready (combinational).
REQ-015 Accept = in_valid & in_ready; on accept, the register loads the decoded fields and out_valid=1 on the next edge (1-cycle latency).
REQ-016 When out_valid & out_ready & !accept, out_valid SHALL clear on the next edge; held fields SHALL hold their values otherwise.
REQ-017 Opcode 0110011 (R-type), funct3: 000 -> 0010 or 0110 if instr[30]; 001 -> 0100; 010 -> 1100; 100 -> 0011; 101 -> 0101 or 0111 if instr[30]; 110 -> 0001; 111 -> 0000; alu_src=0.
REQ-018 Opcode 0010011 (I-type): same mapping, except 000 -> always 0010 (no SUB); alu_src=1.
REQ-019 Opcode 1100011 (branch), funct3: 000 -> 1000, 001 -> 1001, 100 -> 1011, 101 -> 1010; alu_src=0.
REQ-020 Opcodes 0000011, 0100011, 0110111, 0010111, 1101111, 1100111 SHALL encode 0010 with alu_src=1.
REQ-021 funct3 011 in R/I-type, branch funct3 010/011/110/111, and any other opcode are unsupported (see REQ-029).
REQ-022 flush SHALL clear out_valid on the next edge and dominates out_ready; a same-cycle accept SHALL still load and set out_valid=1 (the new instruction is post-redirect).
REQ-023 op_count SHALL increment by 1 on every accept and wrap 0xFFFF -> 0x0000; flush SHALL NOT decrement it.
REQ-024 Back-to-back accept with out_ready=1 SHALL sustain one instruction per cycle without bubbles.

Reset
REQ-025 rst_n low SHALL immediately force out_valid=0, Operation=0000, alu_src=0, illegal=0 and op_count=0, regardless of clk.
REQ-026 in_ready SHALL read 1 while in reset; any accept during reset SHALL be ignored.
REQ-027 Reset deassertion mid-transfer SHALL leave the block empty; the first accept occurs no earlier than the first rising edge with rst_n=1.

Configuration
REQ-028 Macro ALU_OP_ENCODER_ILLEGAL_EN SHALL select illegal-instruction handling.
REQ-029 Defined: unsupported instructions SHALL load Operation=0000, alu_src=0 and illegal=1; undefined: they SHALL load Operation=0010, alu_src=0 and illegal SHALL be constant 0.

Verification
REQ-030 Reset, then instr=0x40B50533 (sub) with in_valid=1, out_ready=1 -> next cycle out_valid=1, Operation=0110, alu_src=0, op_count=1.
REQ-031 instr=0x4030D093 (srai) -> Operation=0111, alu_src=1; instr=0x0030D093 (srli) -> Operation=0101.
REQ-032 Hold out_ready=0 with two instructions offered -> in_ready=0 after the first, Operation holds the first value, op_count=1 until out_ready rises.
REQ-033 flush=1 with a held entry and in_valid=0 -> out_valid=0 next cycle; flush=1 with in_valid=1 -> out_valid=1 holding the new instruction.
REQ-034 instr=0x0020B033 (sltu) -> with ALU_OP_ENCODER_ILLEGAL_EN illegal=1, Operation=0000; without, illegal=0, Operation=0010.
REQ-035 Preload op_count to 0xFFFF via accepts, accept one more -> op_count=0x0000; assert rst_n=0 mid-stream -> all outputs zero immediately.
